// File: rtl/jk_seq_pkg.sv
// ---------------------------------------------------------------------------
// jk_seq_pkg
// Shared types and helpers for the J-K latch command sequencer.
//   - jk_op_e     : command encoding, bit order {J,K}
//   - seq_state_e : sequencer FSM states
//   - resolve_jk  : maps {op, shadow q} to the {J,K} pair actually driven.
//                   It never returns 2'b11.
// ---------------------------------------------------------------------------
package jk_seq_pkg;

    typedef enum logic [1:0] {
        OP_HOLD   = 2'b00,
        OP_RESET  = 2'b01,
        OP_SET    = 2'b10,
        OP_TOGGLE = 2'b11
    } jk_op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_SETUP   = 2'b01,
        ST_APPLY   = 2'b10,
        ST_RELEASE = 2'b11
    } seq_state_e;

    // TOGGLE is turned into an explicit SET or RESET. J=K=1 would make the
    // latch oscillate while its gate is open.
    function automatic logic [1:0] resolve_jk(input logic [1:0] op, input logic q);
        logic [1:0] jk;
        case (op)
            OP_HOLD:   jk = 2'b00;
            OP_RESET:  jk = 2'b01;
            OP_SET:    jk = 2'b10;
            OP_TOGGLE: jk = q ? 2'b01 : 2'b10;
            default:   jk = 2'b00;
        endcase
        return jk;
    endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// ---------------------------------------------------------------------------
// jk_cmd_fifo
// Synchronous FIFO, DEPTH entries of WIDTH bits. DEPTH must be a power of
// two, so the pointers wrap naturally.
// Ports:
//   Clk, Rst_n    : clock, asynchronous active-low reset
//   push_i        : write request; ignored when full, even if a pop happens
//                   in the same cycle
//   push_data_i   : write data
//   pop_i         : read request; ignored when empty
//   pop_data_o    : head entry (valid when !empty_o)
//   full_o        : registered full flag
//   empty_o       : registered empty flag
// ---------------------------------------------------------------------------
module jk_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             full_q;
    logic             empty_q;
    logic             push_s;
    logic             pop_s;

    // The full/empty registers gate requests, so a push is refused when full
    // regardless of a simultaneous pop.
    assign push_s = push_i & ~full_q;
    assign pop_s  = pop_i & ~empty_q;

    assign pop_data_o = mem_q[rd_ptr_q];
    assign full_o     = full_q;
    assign empty_o    = empty_q;

    // Next occupancy; a simultaneous push and pop leave it unchanged.
    always_comb begin
        count_d = count_q;
        if (push_s && !pop_s) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_s && pop_s) begin
            count_d = count_q - CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Storage, pointers and registered flags.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (push_s) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
            full_q  <= (count_d == CNT_W'(DEPTH));
            empty_q <= (count_d == CNT_W'(0));
        end
    end

endmodule

// File: rtl/jk_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// jk_cmd_sequencer
// Buffers J-K commands and drives a gated J-K latch with race-free timing.
// J/K settle one cycle (SETUP) before the gate En rises. Each command keeps
// the gate open for HOLD_CYCLES cycles. Back-to-back commands change J/K at
// the command boundary while En stays high. A burst ends with one RELEASE
// cycle in which the latch clears. TOGGLE is resolved to SET/RESET from the
// shadow q_exp, so J=K=1 is never driven.
//
// Optional build macro: JK_SEQ_CHECK_EN adds q_fb/mismatch feedback checking.
//
// Ports:
//   Clk, Rst_n          : clock, asynchronous active-low reset
//   cmd_valid, cmd_op   : command offer, op = {J,K}
//   cmd_ready           : !full (registered occupancy)
//   J, K, En            : registered latch drive
//   q_exp               : registered shadow of the latch output
//   busy                : FSM not idle or commands pending
//   q_fb     (CHECK_EN) : latch q feedback
//   mismatch (CHECK_EN) : sticky q_fb != q_exp flag
// ---------------------------------------------------------------------------
module jk_cmd_sequencer
    import jk_seq_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 2
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_op,
    output logic       cmd_ready,
    output logic       J,
    output logic       K,
    output logic       En,
    output logic       q_exp,
    output logic       busy
`ifdef JK_SEQ_CHECK_EN
    ,
    input  logic       q_fb,
    output logic       mismatch
`endif
);

    localparam int CNT_W = $clog2(HOLD_CYCLES);

    seq_state_e       state_q;
    logic             j_q;
    logic             k_q;
    logic             en_q;
    logic             q_exp_q;
    logic [CNT_W-1:0] cnt_q;

    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [1:0]       fifo_head_s;
    logic             fifo_pop_s;
    logic             last_s;
    logic [1:0]       jk_res_s;

    jk_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2)
    ) u_fifo (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .push_i      (cmd_valid),
        .push_data_i (cmd_op),
        .pop_i       (fifo_pop_s),
        .pop_data_o  (fifo_head_s),
        .full_o      (fifo_full_s),
        .empty_o     (fifo_empty_s)
    );

    assign last_s = (cnt_q == CNT_W'(HOLD_CYCLES - 1));

    // Resolution uses the shadow in effect at pop time. In IDLE it is 0.
    // At an APPLY boundary it already holds the previous command's result,
    // because q_exp updates at the end of the first APPLY cycle.
    assign jk_res_s = resolve_jk(fifo_head_s, q_exp_q);

    // Pop from IDLE, or at the last APPLY cycle to chain the next command.
    always_comb begin
        fifo_pop_s = 1'b0;
        if (state_q == ST_IDLE) begin
            fifo_pop_s = ~fifo_empty_s;
        end else if ((state_q == ST_APPLY) && last_s) begin
            fifo_pop_s = ~fifo_empty_s;
        end else begin
            fifo_pop_s = 1'b0;
        end
    end

    // Sequencer FSM with registered latch drive and shadow.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= ST_IDLE;
            j_q     <= 1'b0;
            k_q     <= 1'b0;
            en_q    <= 1'b0;
            q_exp_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    en_q    <= 1'b0;
                    q_exp_q <= 1'b0;
                    cnt_q   <= '0;
                    if (!fifo_empty_s) begin
                        j_q     <= jk_res_s[1];
                        k_q     <= jk_res_s[0];
                        state_q <= ST_SETUP;
                    end else begin
                        j_q     <= 1'b0;
                        k_q     <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    en_q    <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= ST_APPLY;
                end
                ST_APPLY: begin
                    // First gate-open cycle: the latch has taken this
                    // command, so the shadow follows. HOLD keeps it.
                    if (cnt_q == CNT_W'(0)) begin
                        case ({j_q, k_q})
                            2'b10:   q_exp_q <= 1'b1;
                            2'b01:   q_exp_q <= 1'b0;
                            default: q_exp_q <= q_exp_q;
                        endcase
                    end
                    if (last_s) begin
                        cnt_q <= '0;
                        if (!fifo_empty_s) begin
                            j_q <= jk_res_s[1];
                            k_q <= jk_res_s[0];
                        end else begin
                            // Latch clears once the gate drops.
                            j_q     <= 1'b0;
                            k_q     <= 1'b0;
                            en_q    <= 1'b0;
                            q_exp_q <= 1'b0;
                            state_q <= ST_RELEASE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    j_q     <= 1'b0;
                    k_q     <= 1'b0;
                    en_q    <= 1'b0;
                    q_exp_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    j_q     <= 1'b0;
                    k_q     <= 1'b0;
                    en_q    <= 1'b0;
                    q_exp_q <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign J         = j_q;
    assign K         = k_q;
    assign En        = en_q;
    assign q_exp     = q_exp_q;
    assign cmd_ready = ~fifo_full_s;
    assign busy      = (state_q != ST_IDLE) | ~fifo_empty_s;

`ifdef JK_SEQ_CHECK_EN
    logic mismatch_q;

    // Compare only after a command's first APPLY cycle, when the shadow
    // already reflects that command.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            mismatch_q <= 1'b0;
        end else if ((state_q == ST_APPLY) && (cnt_q != CNT_W'(0)) && (q_fb != q_exp_q)) begin
            mismatch_q <= 1'b1;
        end else begin
            mismatch_q <= mismatch_q;
        end
    end

    assign mismatch = mismatch_q;
`endif

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_jk_cmd_sequencer
// Scoreboard bench for jk_cmd_sequencer. Accepted ops are queued by the
// driver. The monitor pops one op per HOLD_CYCLES of gate-open time. It
// resolves the op with its own shadow model and checks J/K and q_exp.
// Directed sections check the cycle timing, the FIFO-full behaviour,
// asynchronous reset, and (with JK_SEQ_CHECK_EN) the sticky mismatch flag.
// ---------------------------------------------------------------------------
module tb_jk_cmd_sequencer;

    localparam int DEPTH = 4;
    localparam int HOLD  = 2;

    localparam logic [1:0] C_HOLD   = 2'b00;
    localparam logic [1:0] C_RESET  = 2'b01;
    localparam logic [1:0] C_SET    = 2'b10;
    localparam logic [1:0] C_TOGGLE = 2'b11;

    logic       Clk = 1'b0;
    logic       Rst_n;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic       cmd_ready;
    logic       J;
    logic       K;
    logic       En;
    logic       q_exp;
    logic       busy;
`ifdef JK_SEQ_CHECK_EN
    logic       q_fb;
    logic       mismatch;
    logic       fb_force0 = 1'b0;
    assign q_fb = fb_force0 ? 1'b0 : q_exp;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    logic [1:0] sb_q [$];
    logic       model_q      = 1'b0;
    int         run_cnt      = 0;
    int         last_run_len = 0;
    logic       en_prev      = 1'b0;
    logic       saw_not_ready;

    jk_cmd_sequencer #(
        .DEPTH       (DEPTH),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .cmd_ready (cmd_ready),
        .J         (J),
        .K         (K),
        .En        (En),
        .q_exp     (q_exp),
        .busy      (busy)
`ifdef JK_SEQ_CHECK_EN
        ,
        .q_fb      (q_fb),
        .mismatch  (mismatch)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Offer one op at a negedge and hold it until it is accepted (bounded).
    task automatic push_cmd(input logic [1:0] op);
        int w;
        w = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        while (!cmd_ready && w < 50) begin
            saw_not_ready = 1'b1;
            @(negedge Clk);
            w++;
        end
        if (cmd_ready) begin
            sb_q.push_back(op);
        end else begin
            check_eq("push_timeout", cmd_ready, 1);
        end
        @(negedge Clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while ((busy || En) && w < 200) begin
            @(negedge Clk);
            w++;
        end
        check_eq("idle_timeout", busy, 0);
        @(negedge Clk);
    endtask

    task automatic wait_en();
        int w;
        w = 0;
        while (!En && w < 50) begin
            @(negedge Clk);
            w++;
        end
        check_eq("en_timeout", En, 1);
    endtask

    // Monitor: one scoreboard pop per command, resolved with the bench shadow.
    always @(negedge Clk) begin
        logic [1:0] op;
        logic [1:0] exp_jk;
        if (!Rst_n) begin
            sb_q.delete();
            run_cnt = 0;
            model_q = 1'b0;
            en_prev = 1'b0;
        end else begin
            check_eq("jk_never_11", {31'd0, J & K}, 0);
            if (En) begin
                if (run_cnt % HOLD == 0) begin
                    if (sb_q.size() == 0) begin
                        check_eq("sb_underflow", sb_q.size(), 1);
                    end else begin
                        op = sb_q.pop_front();
                        case (op)
                            C_HOLD:   exp_jk = 2'b00;
                            C_RESET:  exp_jk = 2'b01;
                            C_SET:    exp_jk = 2'b10;
                            default:  exp_jk = model_q ? 2'b01 : 2'b10;
                        endcase
                        check_eq("cmd_jk", {30'd0, J, K}, {30'd0, exp_jk});
                        if (exp_jk == 2'b10) model_q = 1'b1;
                        else if (exp_jk == 2'b01) model_q = 1'b0;
                    end
                end else if (run_cnt % HOLD == 1) begin
                    check_eq("cmd_q_exp", q_exp, model_q);
                end
                run_cnt++;
            end else if (en_prev) begin
                check_eq("run_len_multiple", run_cnt % HOLD, 0);
                check_eq("release_q_exp", q_exp, 0);
                check_eq("release_jk", {30'd0, J, K}, 0);
                last_run_len = run_cnt;
                run_cnt = 0;
                model_q = 1'b0;
            end
            en_prev = En;
        end
    end

    initial begin
        logic saw_en;
        Rst_n         = 1'b0;
        cmd_valid     = 1'b0;
        cmd_op        = 2'b00;
        saw_not_ready = 1'b0;
        repeat (3) @(negedge Clk);

        // Reset state
        check_eq("rst_J", J, 0);
        check_eq("rst_K", K, 0);
        check_eq("rst_En", En, 0);
        check_eq("rst_q_exp", q_exp, 0);
        check_eq("rst_ready", cmd_ready, 1);
        check_eq("rst_busy", busy, 0);
`ifdef JK_SEQ_CHECK_EN
        check_eq("rst_mismatch", mismatch, 0);
`endif
        Rst_n = 1'b1;
        @(negedge Clk);

        // Single SET timing: accepted at end of cycle N
        push_cmd(C_SET);                       // now in cycle N+1
        check_eq("n1_busy", busy, 1);
        check_eq("n1_En", En, 0);
        @(negedge Clk);                        // N+2 SETUP
        check_eq("n2_jk", {30'd0, J, K}, 2);
        check_eq("n2_En", En, 0);
        @(negedge Clk);                        // N+3
        check_eq("n3_En", En, 1);
        check_eq("n3_q_exp", q_exp, 0);
        @(negedge Clk);                        // N+4
        check_eq("n4_En", En, 1);
        check_eq("n4_q_exp", q_exp, 1);
        @(negedge Clk);                        // N+5 RELEASE
        check_eq("n5_En", En, 0);
        check_eq("n5_q_exp", q_exp, 0);
        check_eq("n5_busy", busy, 1);
        @(negedge Clk);                        // N+6 IDLE
        check_eq("n6_busy", busy, 0);

        // Burst SET, TOGGLE, TOGGLE: 6 contiguous gate cycles
        push_cmd(C_SET);
        push_cmd(C_TOGGLE);
        push_cmd(C_TOGGLE);
        wait_idle();
        check_eq("burst_run_len", last_run_len, 3 * HOLD);

        // HOLD first in a burst
        push_cmd(C_HOLD);
        wait_idle();
        check_eq("hold_run_len", last_run_len, HOLD);

        // Fill the FIFO: back-to-back offers outpace the drain
        saw_not_ready = 1'b0;
        push_cmd(C_SET);
        push_cmd(C_TOGGLE);
        push_cmd(C_TOGGLE);
        push_cmd(C_HOLD);
        push_cmd(C_RESET);
        push_cmd(C_TOGGLE);
        push_cmd(C_SET);
        push_cmd(C_TOGGLE);
        push_cmd(C_HOLD);
        check_eq("full_backpressure", saw_not_ready, 1);
        wait_idle();
        check_eq("full_run_len", last_run_len, 9 * HOLD);
        check_eq("sb_drained_full", sb_q.size(), 0);

        // Asynchronous reset mid-APPLY
        push_cmd(C_SET);
        push_cmd(C_TOGGLE);
        push_cmd(C_SET);
        push_cmd(C_TOGGLE);
        wait_en();
        #2;
        Rst_n = 1'b0;
        #1;
        check_eq("arst_En", En, 0);
        check_eq("arst_J", J, 0);
        check_eq("arst_K", K, 0);
        check_eq("arst_q_exp", q_exp, 0);
        check_eq("arst_ready", cmd_ready, 1);
        check_eq("arst_busy", busy, 0);
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
        saw_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            saw_en = saw_en | En | busy;
        end
        check_eq("arst_no_residual", saw_en, 0);

`ifdef JK_SEQ_CHECK_EN
        // Sticky mismatch
        check_eq("mm_clear_before", mismatch, 0);
        push_cmd(C_SET);
        wait_en();                             // first APPLY cycle
        fb_force0 = 1'b1;
        @(negedge Clk);                        // second APPLY cycle, q_exp=1
        @(negedge Clk);
        fb_force0 = 1'b0;
        check_eq("mm_set", mismatch, 1);
        wait_idle();
        push_cmd(C_SET);
        push_cmd(C_TOGGLE);
        wait_idle();
        check_eq("mm_sticky", mismatch, 1);
`endif

        check_eq("sb_final_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
